// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision float datapath.
//
// Contents:
//   state_e    - conversion FSM states
//   EXP_BIAS   - IEEE-754 single-precision exponent bias
//   EXP_W      - exponent field width
//   FRAC_W     - fraction field width
//   EXP_BASE   - biased exponent of a 32-bit magnitude whose MSB sits in bit 31
//   float_pack - assembles {sign, exp, frac} into a 32-bit word
package fp_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;

  localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;

  // A magnitude normalised so that bit 31 is the leading one has weight 2^31,
  // so its biased exponent is EXP_BIAS + 31.
  localparam logic [EXP_W-1:0] EXP_BASE = 8'd158;

  typedef enum logic [2:0] {
    StIdle,
    StAbs,
    StNorm,
    StRound,
    StDone
  } state_e;

  function automatic logic [31:0] float_pack(input logic             sign,
                                             input logic [EXP_W-1:0]  exp,
                                             input logic [FRAC_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a truncated fraction.
//
// Ports:
//   frac_i   - fraction bits kept after truncation
//   guard_i  - first discarded bit
//   sticky_i - OR of all remaining discarded bits
//   frac_o   - rounded fraction
//   carry_o  - set when rounding overflowed the fraction field; the caller
//              bumps its exponent and frac_o is zero in that case
//
// Purely combinational so it can be shared with other float datapaths.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [FRAC_W-1:0] frac_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  output logic [FRAC_W-1:0] frac_o,
  output logic              carry_o
);

  logic              round_up;
  logic [FRAC_W:0]   frac_inc;

  // Round up when above half, or exactly half and the kept LSB is odd.
  assign round_up = guard_i & (sticky_i | frac_i[0]);

  assign frac_inc = {1'b0, frac_i} + {{FRAC_W{1'b0}}, round_up};

  assign frac_o  = frac_inc[FRAC_W-1:0];
  assign carry_o = frac_inc[FRAC_W];

endmodule

// File: rtl/int2fp.sv
// Signed 32-bit integer to IEEE-754 single-precision converter.
//
// Multi-cycle: absolute value, then one-bit-per-cycle normalisation, then
// round-to-nearest-even. A new start aborts any conversion in progress.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   start  - conversion request, sampled on the rising edge
//   a      - signed operand, captured on the start edge only
//   result - registered float {sign, exp[7:0], frac[22:0]}
//   done   - high while result holds a finished conversion
//   busy   - high from the start capture until done rises
module int2fp
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  // Control state and visible outputs (reset).
  state_e      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  // Datapath (no reset; always written before being consumed).
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [31:0]      mag_q, mag_d;

  // Absolute value of the captured operand; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  logic [31:0] abs_val;
  assign abs_val = mag_q[31] ? (~mag_q + 32'd1) : mag_q;

  // Rounding of the normalised magnitude: bit 31 is the hidden one.
  logic [FRAC_W-1:0] frac_rnd;
  logic              frac_carry;
  logic              sticky;

  assign sticky = |mag_q[6:0];

  fp_round_rne u_round (
    .frac_i   (mag_q[30:8]),
    .guard_i  (mag_q[7]),
    .sticky_i (sticky),
    .frac_o   (frac_rnd),
    .carry_o  (frac_carry)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    done_d   = done_q;
    busy_d   = busy_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mag_d    = mag_q;

    if (start) begin
      // Raw operand parks in mag until ABS derives sign and magnitude.
      mag_d   = a;
      done_d  = 1'b0;
      busy_d  = 1'b1;
      state_d = StAbs;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          // Hold everything until the next start.
        end

        StAbs: begin
          sign_d = mag_q[31];
          mag_d  = abs_val;
          exp_d  = EXP_BASE;
          if (abs_val == 32'd0) begin
            // Zero bypasses normalisation; sign is dropped so -0 never appears.
            result_d = 32'h0000_0000;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = StDone;
          end else begin
            state_d = StNorm;
          end
        end

        StNorm: begin
          if (mag_q[31]) begin
            state_d = StRound;
          end else begin
            mag_d = {mag_q[30:0], 1'b0};
            exp_d = exp_q - 8'd1;
          end
        end

        StRound: begin
          // A carry leaves frac_rnd at zero, so only the exponent moves.
          result_d = float_pack(sign_q, exp_q + {{(EXP_W-1){1'b0}}, frac_carry}, frac_rnd);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StDone;
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      result_q <= 32'h0000_0000;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    exp_q  <= exp_d;
    mag_q  <= mag_d;
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_int2fp.sv
// Self-checking bench for int2fp: directed corner cases, randomized operands
// against an arithmetic reference model, abort, mid-run reset and hold.
module tb_int2fp;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] result;
  logic        done;
  logic        busy;

  int unsigned n_vec;
  int unsigned n_bad;
  logic [31:0] exp_prev;  // result the DUT should currently be holding

  int2fp dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint unsigned ref_mag(input logic [31:0] v);
    longint unsigned vv;
    vv = {32'd0, v};
    return v[31] ? (64'h1_0000_0000 - vv) : vv;
  endfunction

  function automatic int ref_msb(input longint unsigned m);
    int p;
    p = -1;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    return p;
  endfunction

  function automatic logic [31:0] ref_float(input logic [31:0] v);
    longint unsigned m, keep, rem, half;
    int p, e, sh;
    logic [7:0]  ef;
    logic [22:0] ff;
    if (v == 32'd0) return 32'd0;
    m = ref_mag(v);
    p = ref_msb(m);
    e = 127 + p;
    if (p <= 23) begin
      keep = m << (23 - p);
    end else begin
      sh   = p - 23;
      keep = m >> sh;
      rem  = m & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 1;
      if (keep == (64'd1 << 24)) begin
        keep = keep >> 1;
        e    = e + 1;
      end
    end
    ef = e[7:0];
    ff = keep[22:0];
    return {v[31], ef, ff};
  endfunction

  function automatic int ref_latency(input logic [31:0] v);
    if (v == 32'd0) return 1;
    return (31 - ref_msb(ref_mag(v))) + 3;
  endfunction

  // ---------------- scenarios ----------------
  // One full conversion: start edge, busy check, bounded wait for done,
  // latency and result check.
  task automatic run_conv(input logic [31:0] v, input string name);
    logic [31:0] exp_res;
    int          exp_lat;
    int          seen;
    exp_res = ref_float(v);
    exp_lat = ref_latency(v);

    @(negedge clk);
    start = 1'b1;
    a     = v;
    @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s start_flags: got busy=%b done=%b expected busy=1 done=0",
               name, busy, done);
    end
    n_vec++;
    if (result !== exp_prev) begin
      n_bad++;
      $display("FAIL %s result_held: got %h expected %h", name, result, exp_prev);
    end
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;

    seen = 0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        seen = n;
        break;
      end
    end
    n_vec++;
    if (seen != exp_lat) begin
      n_bad++;
      $display("FAIL %s latency: a=%h got edge %0d expected edge %0d (0 = timeout)",
               name, v, seen, exp_lat);
    end
    n_vec++;
    if (result !== exp_res || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s result: a=%h got %h busy=%b expected %h busy=0",
               name, v, result, busy, exp_res);
    end
    exp_prev = exp_res;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    a     = 32'd0;
    #2;
    n_vec++;
    if (result !== 32'd0 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got result=%h done=%b busy=%b expected 0/0/0",
               result, done, busy);
    end
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    exp_prev = 32'd0;
  endtask

  task automatic test_directed();
    run_conv(32'h0000_0001, "one");
    run_conv(32'hFFFF_FFFF, "minus_one");
    run_conv(32'h0000_0000, "zero");
    run_conv(32'h8000_0000, "int_min");
    run_conv(32'h0100_0001, "tie_even");
    run_conv(32'h7FFF_FFFF, "round_carry");
    run_conv(32'h0100_0003, "tie_odd");
    run_conv(32'hFEFF_FFFF, "neg_round");
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int i = 0; i < 40; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      run_conv(v, "random");
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    start = 1'b1;
    a     = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    repeat (5) @(negedge clk);  // deep inside NORM
    run_conv(32'h0000_0002, "abort_restart");
  endtask

  task automatic test_hold();
    run_conv(32'h1234_5678, "hold_setup");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = $urandom;
      @(posedge clk);
      #1;
      n_vec++;
      if (done !== 1'b1 || result !== exp_prev) begin
        n_bad++;
        $display("FAIL hold cycle %0d: got done=%b result=%h expected done=1 result=%h",
                 i, done, result, exp_prev);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    a     = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b0;  // asynchronous: between clock edges
    #1;
    n_vec++;
    if (result !== 32'd0 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got result=%h done=%b busy=%b expected 0/0/0",
               result, done, busy);
    end
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    exp_prev = 32'd0;
    run_conv(32'hFFFF_FF9C, "after_reset");
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    exp_prev = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/int2fp.md
INT2FP -- requirements
Module: int2fp

Interface
REQ-001 The block SHALL use parameter none; the format is fixed IEEE-754 single precision with round-to-nearest-even.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  asynchronous, active-low reset; the polarity and synchronicity are fixed.
REQ-004 start  input  1  conversion request, sampled on the rising edge of clk.
REQ-005 a  input  32  signed two's-complement integer operand, captured only on the start edge.
REQ-006 result  output  32  registered float: {sign, exp[7:0], frac[22:0]}.
REQ-007 done  output  1  registered; high while result is valid.
REQ-008 busy  output  1  registered; high from the start capture until done rises.

Function
REQ-009 State machine SHALL have states IDLE, ABS, NORM, ROUND, DONE.
REQ-010 A start sampled high in any state SHALL capture a, clear done, set busy and enter ABS (abort-and-restart); result SHALL keep its old value until overwritten.
REQ-011 ABS SHALL capture sign=a[31] and mag=|a| (32-bit unsigned, so 0x80000000 gives mag 0x80000000), and set exp=158.
REQ-012 ABS with mag==0 SHALL write result=0x00000000, set done, clear busy and enter DONE. Negative zero is never produced.
REQ-013 NORM with mag[31]==0 SHALL shift mag left by 1 and decrement exp, staying in NORM (one bit per cycle); with mag[31]==1 it SHALL go to ROUND.
REQ-014 ROUND SHALL take frac=mag[30:8], guard=mag[7], sticky=OR(mag[6:0]), and increment frac when guard AND (sticky OR frac[0]).
REQ-015 A frac carry-out on rounding SHALL give frac=0 and exp+1.
REQ-016 ROUND SHALL write result={sign,exp,frac}, set done, clear busy and enter DONE, all on the same edge.
REQ-017 Latency: let lz be the leading-zero count of mag. done SHALL be high after edge lz+3 counted from the start edge (edge 0). For a zero input, done SHALL be high after edge 1.
REQ-018 DONE SHALL hold result and done stable until the next start; IDLE and DONE SHALL ignore a when start is low.
REQ-019 Overflow, NaN and Inf SHALL NOT occur (the maximum exp is 158); no exception outputs exist.

Reset
REQ-020 While reset is low, the block SHALL force state=IDLE, result=0, done=0 and busy=0 immediately, regardless of clk.
REQ-021 A reset during any state SHALL discard the conversion in progress; the first start after reset is released SHALL behave as in REQ-010.
REQ-022 Internal datapath registers (mag, exp, sign) need no reset value.

Structure
REQ-023 A shared package fp_pkg SHALL hold the state enum, EXP_BIAS=127, EXP_W=8, FRAC_W=23, and the int32-to-float exponent base 158.
REQ-024 The rounding logic SHALL be one combinational sub-module, fp_round_rne. Inputs: frac, guard, sticky. Outputs: the rounded frac and a carry flag. It is reusable by the adder path.
REQ-025 Everything else SHALL stay in int2fp; no other hierarchy.

Verification
REQ-026 a=0x00000001 -> result 0x3F800000, done after edge 34 (lz=31).
REQ-027 a=0xFFFFFFFF (-1) -> 0xBF800000. a=0x00000000 -> 0x00000000 with done after edge 1.
REQ-028 a=0x80000000 -> 0xCF000000, done after edge 3 (lz=0).
REQ-029 Rounding cases:
- a=0x01000001 (tie, even LSB) -> 0x4B800000.
- a=0x7FFFFFFF (round-up carry) -> 0x4F000000.
REQ-030 Abort, reset and hold cases:
- start again mid-NORM with a=2 -> only 0x40000000 is reported.
- reset low mid-NORM -> done=0, busy=0 and result=0 at once.
- done stays high for 10 idle cycles.
